// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core types; multiplier opcodes and the EX-stage multiplier issue FSM states.
package riscv_pkg;

    typedef enum logic [2:0] {
        MUL_MAC32,
        MUL_MSU32,
        MUL_I,
        MUL_IR,
        MUL_DOT8,
        MUL_DOT16,
        MUL_H
    } mul_opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_WB,
        DRAIN
    } mul_issue_state_e;

endpackage

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: latches an ID multiply request, holds it on the multiplier port until completion,
// and retires the result to writeback through a one-entry register; handles flush and timeout.
module mul_issue_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    output logic        id_ready_o,
    input  mul_opcode_e id_operator_i,
    input  logic [1:0]  id_short_signed_i,
    input  logic        id_short_subword_i,
    input  logic [31:0] id_operand_a_i,
    input  logic [31:0] id_operand_b_i,
    input  logic [31:0] id_operand_c_i,
    input  logic [4:0]  id_imm_i,
    input  logic [4:0]  id_rd_i,
    input  logic        flush_i,
    output logic        mul_enable_o,
    output mul_opcode_e mul_operator_o,
    output logic [1:0]  mul_short_signed_o,
    output logic        mul_short_subword_o,
    output logic [31:0] mul_operand_a_o,
    output logic [31:0] mul_operand_b_o,
    output logic [31:0] mul_operand_c_o,
    output logic [4:0]  mul_imm_o,
    output logic        mul_ex_ready_o,
    input  logic [31:0] mul_result_i,
    input  logic        mul_ready_i,
    input  logic        mul_multicycle_i,
    input  logic        mul_mulh_active_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_result_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    mul_issue_state_e state_q, state_d;
    mul_opcode_e      op_q;
    logic [1:0]       sgn_q;
    logic             sub_q;
    logic [31:0]      a_q, b_q, c_q, res_q;
    logic [4:0]       imm_q, rd_q, wb_rd_q;
    logic [CW-1:0]    cnt_q;
    logic             err_q, accept, issue, unused_status;

    assign unused_status = mul_multicycle_i | mul_mulh_active_i;
    assign issue = state_q == ISSUE;
    assign mul_enable_o = issue | state_q == DRAIN;
    assign mul_ex_ready_o = mul_enable_o & mul_ready_i;
    assign id_ready_o = !flush_i & (state_q == IDLE | (state_q == WAIT_WB & wb_ready_i));
    assign accept = id_valid_i & id_ready_o;
    assign wb_valid_o = state_q == WAIT_WB;
    assign busy_o = state_q != IDLE;
    assign err_o = err_q;
    assign mul_operator_o = op_q;
    assign mul_short_signed_o = sgn_q;
    assign mul_short_subword_o = sub_q;
    assign mul_operand_a_o = a_q;
    assign mul_operand_b_o = b_q;
    assign mul_operand_c_o = c_q;
    assign mul_imm_o = imm_q;
    assign wb_rd_o = wb_rd_q;
    assign wb_result_o = res_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = flush_i ? (mul_ready_i ? IDLE : DRAIN) : (mul_ready_i ? WAIT_WB : ISSUE);
            WAIT_WB: state_d = flush_i ? IDLE : (wb_ready_i ? (accept ? ISSUE : IDLE) : WAIT_WB);
            DRAIN:   state_d = mul_ready_i ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= MUL_MAC32;
            sgn_q   <= '0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            wb_rd_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= id_operator_i;
                sgn_q <= id_short_signed_i;
                sub_q <= id_short_subword_i;
                a_q   <= id_operand_a_i;
                b_q   <= id_operand_b_i;
                c_q   <= id_operand_c_i;
                imm_q <= id_imm_i;
                rd_q  <= id_rd_i;
                cnt_q <= '0;
            end else if (issue & !mul_ready_i) begin
                cnt_q <= cnt_q == TMAX ? TMAX : cnt_q + 1'b1;
                err_q <= err_q | (cnt_q == TLAST);
            end
            // a flushed completion is retired to the multiplier but never reaches writeback
            if (issue & mul_ready_i & !flush_i) begin
                res_q   <= mul_result_i;
                wb_rd_q <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed bench with a behavioural fixed-latency multiplier responder.
module tb_mul_issue_ctrl;
    import riscv_pkg::*;

    logic        clk = 0, rst = 1;
    logic        id_valid_i = 0, id_ready_o;
    mul_opcode_e id_operator_i = MUL_MAC32;
    logic [1:0]  id_short_signed_i = 0;
    logic        id_short_subword_i = 0;
    logic [31:0] id_operand_a_i = 0, id_operand_b_i = 0, id_operand_c_i = 0;
    logic [4:0]  id_imm_i = 0, id_rd_i = 0;
    logic        flush_i = 0;
    logic        mul_enable_o, mul_short_subword_o, mul_ex_ready_o;
    mul_opcode_e mul_operator_o;
    logic [1:0]  mul_short_signed_o;
    logic [31:0] mul_operand_a_o, mul_operand_b_o, mul_operand_c_o, mul_result_i;
    logic [4:0]  mul_imm_o, wb_rd_o;
    logic        mul_ready_i, wb_valid_o, wb_ready_i = 1, busy_o, err_o;
    logic [31:0] wb_result_o;

    int total = 0, bad = 0, lat = 1, en_cnt = 0, ex_pulses = 0;
    logic seen_wb;

    mul_issue_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_operator_i(id_operator_i), .id_short_signed_i(id_short_signed_i),
        .id_short_subword_i(id_short_subword_i),
        .id_operand_a_i(id_operand_a_i), .id_operand_b_i(id_operand_b_i), .id_operand_c_i(id_operand_c_i),
        .id_imm_i(id_imm_i), .id_rd_i(id_rd_i), .flush_i(flush_i),
        .mul_enable_o(mul_enable_o), .mul_operator_o(mul_operator_o),
        .mul_short_signed_o(mul_short_signed_o), .mul_short_subword_o(mul_short_subword_o),
        .mul_operand_a_o(mul_operand_a_o), .mul_operand_b_o(mul_operand_b_o), .mul_operand_c_o(mul_operand_c_o),
        .mul_imm_o(mul_imm_o), .mul_ex_ready_o(mul_ex_ready_o),
        .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i),
        .mul_multicycle_i(1'b0), .mul_mulh_active_i(1'b0),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_result_o(wb_result_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // responder: ready in the lat-th consecutive enabled cycle
    always @(posedge clk or posedge rst)
        if (rst) en_cnt <= 0;
        else en_cnt <= (mul_enable_o && !mul_ready_i) ? en_cnt + 1 : 0;
    assign mul_ready_i = mul_enable_o && (en_cnt == lat - 1);
    assign mul_result_i = mul_operand_a_o * mul_operand_b_o;
    always @(posedge clk) if (mul_ex_ready_o) ex_pulses <= ex_pulses + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input mul_opcode_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        id_valid_i = 1; id_operator_i = op; id_operand_a_i = a; id_operand_b_i = b; id_rd_i = rd;
        step();
        id_valid_i = 0;
    endtask

    initial begin
        #3;
        chk("rst_id_ready", id_ready_o, 1);
        chk("rst_enable", mul_enable_o, 0);
        chk("rst_ex_ready", mul_ex_ready_o, 0);
        chk("rst_wb", {wb_valid_o, busy_o, err_o, wb_rd_o}, 0);
        chk("rst_res", wb_result_o, 0);
        chk("rst_op_a", mul_operand_a_o, 0);
        step(); step();
        rst = 0;

        lat = 1; wb_ready_i = 1; ex_pulses = 0;
        issue(MUL_MAC32, 3, 5, 7);
        chk("t1_c1_enable", mul_enable_o, 1);
        chk("t1_c1_exready", mul_ex_ready_o, 1);
        chk("t1_c1_idready", id_ready_o, 0);
        step();
        chk("t1_c2_wbvalid", wb_valid_o, 1);
        chk("t1_c2_result", wb_result_o, 15);
        chk("t1_c2_rd", wb_rd_o, 7);
        chk("t1_c2_enable", mul_enable_o, 0);
        step();
        chk("t1_idle", {busy_o, wb_valid_o}, 0);
        chk("t1_pulses", ex_pulses, 1);

        lat = 5;
        issue(MUL_H, 32'h1234_5678, 32'h10, 9);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("t2_c%0d_a", k), mul_operand_a_o, 32'h1234_5678);
            chk($sformatf("t2_c%0d_b", k), mul_operand_b_o, 32'h10);
            chk($sformatf("t2_c%0d_en_wb", k), {mul_enable_o, wb_valid_o}, 2'b10);
            step();
        end
        chk("t2_c6_wbvalid", wb_valid_o, 1);
        chk("t2_c6_result", wb_result_o, 32'h2345_6780);
        chk("t2_c6_rd", wb_rd_o, 9);
        chk("t2_err", err_o, 0);
        step();

        lat = 1; wb_ready_i = 0;
        issue(MUL_MAC32, 6, 7, 3);
        step();
        id_valid_i = 1; id_operand_a_i = 2; id_operand_b_i = 9; id_rd_i = 4;
        for (int k = 0; k < 3; k++) begin
            chk("t3_hold_valid", wb_valid_o, 1);
            chk("t3_hold_result", wb_result_o, 42);
            chk("t3_hold_rd", wb_rd_o, 3);
            chk("t3_hold_idready", id_ready_o, 0);
            step();
        end
        wb_ready_i = 1;
        #1;
        chk("t3_release_idready", id_ready_o, 1);
        step();
        id_valid_i = 0;
        chk("t3_b2b_issue", {busy_o, mul_enable_o, wb_valid_o}, 3'b110);
        chk("t3_b2b_a", mul_operand_a_o, 2);
        step();
        chk("t3_b2b_result", wb_result_o, 18);
        chk("t3_b2b_rd", wb_rd_o, 4);
        step();

        lat = 5; seen_wb = 0;
        issue(MUL_H, 11, 13, 5);
        step();
        flush_i = 1;
        step();
        flush_i = 0;
        chk("t4_drain", {busy_o, mul_enable_o, id_ready_o, wb_valid_o}, 4'b1100);
        for (int k = 0; k < 10 && busy_o; k++) begin
            seen_wb |= wb_valid_o;
            step();
        end
        chk("t4_drained", busy_o, 0);
        chk("t4_no_wb", seen_wb | wb_valid_o, 0);
        chk("t4_idready", id_ready_o, 1);

        lat = 12;
        issue(MUL_H, 4, 4, 6);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("t5_c%0d_err_low", k), err_o, 0);
            step();
        end
        chk("t5_c9_err", err_o, 1);
        for (int k = 0; k < 4; k++) step();
        chk("t5_c13_wbvalid", wb_valid_o, 1);
        chk("t5_c13_result", wb_result_o, 16);
        chk("t5_c13_err", err_o, 1);
        step();
        chk("t5_err_sticky", err_o, 1);

        lat = 5;
        issue(MUL_H, 8, 8, 2);
        step();
        rst = 1;
        #1;
        chk("t6_rst_enable", mul_enable_o, 0);
        chk("t6_rst_state", {busy_o, id_ready_o, err_o, wb_valid_o}, 4'b0100);
        chk("t6_rst_a", mul_operand_a_o, 0);
        chk("t6_rst_res", wb_result_o, 0);
        step();
        rst = 0; lat = 1;
        issue(MUL_MAC32, 10, 10, 1);
        step();
        chk("t6_after_valid", wb_valid_o, 1);
        chk("t6_after_result", wb_result_o, 100);
        chk("t6_after_rd", wb_rd_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

EX-stage initiator for the integer multiplier: accepts one multiply/MAC request per handshake from the ID stage, latches the operands, and drives the multiplier port with the request held stable until the multiplier reports completion. It then retires the result to writeback through a one-entry result register. It also handles pipeline flushes and multi-cycle (MULH) latency, and flags any multiplier operation that exceeds a cycle budget.

## Interface
- TIMEOUT, 8, maximum cycles spent in ISSUE before `err_o` is set.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- id_valid_i / id_ready_o  in/out  1  request handshake with ID.
- id_operator_i  in  riscv_pkg::mul_opcode_e  multiply opcode.
- id_short_signed_i  in  2  operand signedness.
- id_short_subword_i  in  1  subword select.
- id_operand_a_i, id_operand_b_i, id_operand_c_i  in  32 each  operands (c is the accumulator).
- id_imm_i  in  5  shift immediate.
- id_rd_i  in  5  destination register.
- flush_i  in  1  kill any in-flight operation.
- mul_enable_o, mul_operator_o, mul_short_signed_o, mul_short_subword_o, mul_operand_a_o, mul_operand_b_o, mul_operand_c_o, mul_imm_o  out  (widths match the id_* inputs)  request to the multiplier.
- mul_ex_ready_o  out  1  retire strobe to the multiplier.
- mul_result_i  in  32  multiplier result.
- mul_ready_i  in  1  multiplier completion.
- mul_multicycle_i  in  1  multiplier status; informational.
- mul_mulh_active_i  in  1  multiplier status; informational.
- wb_valid_o / wb_ready_i  out/in  1  writeback handshake.
- wb_rd_o  out  5  destination register to writeback.
- wb_result_o  out  32  result to writeback.
- busy_o  out  1  state != IDLE.
- err_o  out  1  sticky timeout flag.

## Operation
- **Multiplier contract.** With `mul_enable_o`=1 and operands stable, the multiplier raises `mul_ready_i` when the result is valid. `mul_ex_ready_o`=1 in that same cycle retires the operation. Single-cycle ops return `mul_ready_i`=1 in the first enabled cycle.
- **State IDLE.**
  - `id_ready_o`=1.
  - On `id_valid_i`: latch all id_* fields into request registers, clear the timeout counter, go to ISSUE.
- **State ISSUE.**
  - `mul_enable_o`=1; `mul_*` outputs come from the request registers and stay constant.
  - `mul_ex_ready_o` = `mul_ready_i`.
  - When `mul_ready_i`=1: capture `mul_result_i` and the latched rd into the result register, go to WAIT_WB.
  - Otherwise the timeout counter increments. Reaching TIMEOUT sets `err_o`. Operation continues; `err_o` is cleared only by reset.
- **State WAIT_WB.**
  - `wb_valid_o`=1.
  - When `wb_ready_i`=1 and `id_valid_i`=1: latch the new request and go to ISSUE (back-to-back).
  - When `wb_ready_i`=1 and `id_valid_i`=0: go to IDLE.
  - `id_ready_o` = `wb_ready_i`.
- **State DRAIN.**
  - `mul_enable_o`=1 and `mul_ex_ready_o` = `mul_ready_i`.
  - When `mul_ready_i`=1: discard the result, go to IDLE.
  - `id_ready_o`=0 and `wb_valid_o`=0.
- **Flush rules** (flush has priority over every other transition):
  - From IDLE or WAIT_WB: go to IDLE. A pending wb result is dropped and no ID request is accepted that cycle.
  - From ISSUE with `mul_ready_i`=1: retire to the multiplier, discard the result, go to IDLE.
  - From ISSUE with `mul_ready_i`=0: go to DRAIN. The multiplier is never abandoned mid-MULH.
  - In DRAIN: flush is ignored.
- **Registers.** All operand registers are plain 32-bit; no arithmetic is done in this block. The timeout counter is $clog2(TIMEOUT+1) bits and saturates.

## Timing
- **Reset values:**
  - state=IDLE, so `id_ready_o`=1.
  - `mul_enable_o`=0, `mul_ex_ready_o`=0, all `mul_*` data=0.
  - `wb_valid_o`=0, `wb_result_o`=0, `wb_rd_o`=0.
  - `busy_o`=0, `err_o`=0.
- **Reset mid-operation:** state returns to IDLE immediately. The multiplier sees `mul_enable_o` fall asynchronously; its own reset is shared.
- **Single-cycle op latency:**
  - ID accept at cycle 0.
  - `mul_enable_o` at cycle 1.
  - `wb_valid_o` at cycle 2.
- **N-cycle op** (`mul_ready_i` in the N-th enabled cycle): `wb_valid_o` at cycle N+1.
- **Throughput:** one op per 2 cycles minimum, given back-to-back from WAIT_WB.
- **Stability:** `wb_result_o` and `wb_rd_o` are held stable while `wb_valid_o`=1 and `wb_ready_i`=0.

## Structure
- `mul_issue_state_e` (IDLE, ISSUE, WAIT_WB, DRAIN) is added to riscv_pkg, next to the existing `mul_opcode_e`.
- The design is a flat single module with no sub-module.
- The bench uses a behavioural multiplier responder with configurable latency.

## Test plan
- MUL 3×5, stub latency 1, `wb_ready_i`=1 → `wb_valid_o` at cycle 2 with `wb_result_o`=15 and the `id_rd_i` value; `mul_ex_ready_o` pulses once.
- MULH, stub latency 5 → `mul_operand_a_o`/`mul_operand_b_o` stay constant for 5 cycles; `wb_valid_o` at cycle 6; `err_o` stays 0.
- `wb_ready_i` held low for 3 cycles after a result → `wb_valid_o` and `wb_result_o` stable, `id_ready_o`=0; on release, a queued `id_valid_i` goes directly to ISSUE.
- Flush at the 2nd cycle of a 5-cycle MULH → DRAIN; the result is discarded when `mul_ready_i` arrives, `wb_valid_o` never rises, then IDLE with `id_ready_o`=1.
- Stub latency 12 with TIMEOUT=8 → `err_o` rises after 8 ISSUE cycles and stays high; the result is still written back.
- Reset asserted during ISSUE → all outputs take their reset values immediately; a new op after reset completes normally.
